// File: rtl/mul4_seq_ctrl_pkg.sv
// Shared constants and state encoding for the 4x4 sequential shift-add multiplier.
package mul4_seq_ctrl_pkg;

  localparam int OPW  = 4;
  localparam int ITER = 4;
  localparam int ITW  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul4_seq_ctrl_add4_core.sv
// 4-bit combinational ripple-carry adder used for every partial-product accumulation.
module add4_core (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]     = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
  end

  assign cout = c_s[4];

endmodule

// File: rtl/mul4_seq_ctrl.sv
// Sequential unsigned 4x4 multiplier: one shift-add step per clock, valid/ready
// handshake on both sides, synchronous abort and registered product.
module mul4_seq_ctrl
  import mul4_seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] product
);

  state_e             state_q, state_d;
  logic [OPW-1:0]     mcand_q, mcand_d;
  logic [OPW-1:0]     hi_q, hi_d;
  logic [OPW-1:0]     lo_q, lo_d;
  logic [ITW-1:0]     iter_q, iter_d;
  logic [2*OPW-1:0]   product_q, product_d;

  logic [OPW-1:0]     addend_s;
  logic [OPW-1:0]     sum_s;
  logic               cout_s;

  assign addend_s = lo_q[0] ? mcand_q : {OPW{1'b0}};

  add4_core u_add (
    .x    (hi_q),
    .y    (addend_s),
    .cin  (1'b0),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Next-state and datapath control; the 5-bit adder result shifts right into {hi,lo}.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    iter_d    = iter_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = {OPW{1'b0}};
          iter_d  = {ITW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          hi_d   = {cout_s, sum_s[OPW-1:1]};
          lo_d   = {sum_s[0], lo_q[OPW-1:1]};
          iter_d = iter_q + 2'd1;
          if (iter_q == ITW'(ITER - 1)) begin
            product_d = {cout_s, sum_s, lo_q[OPW-1:1]};
            state_d   = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= {OPW{1'b0}};
      hi_q      <= {OPW{1'b0}};
      lo_q      <= {OPW{1'b0}};
      iter_q    <= {ITW{1'b0}};
      product_q <= {(2*OPW){1'b0}};
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      iter_q    <= iter_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Directed self-checking bench for mul4_seq_ctrl with hand-computed products.
module tb_mul4_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       abort;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  mul4_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with out_ready high: checks latency, result and 1-cycle pulse.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("op_busy", {7'd0, busy}, 8'd1);
    check("op_in_ready_run", {7'd0, in_ready}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check("op_no_early_valid", {7'd0, out_valid}, 8'd0);
      step();
    end
    check("op_no_early_valid4", {7'd0, out_valid}, 8'd0);
    step();
    check("op_out_valid", {7'd0, out_valid}, 8'd1);
    check("op_product", product, exp);
    step();
    check("op_pulse_end", {7'd0, out_valid}, 8'd0);
    check("op_idle", {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0; abort = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_product", product, 8'h00);
    step(); step();
    rst_n = 1'b1;

    do_op(4'd15, 4'd15, 8'hE1);
    do_op(4'd9, 4'd6, 8'h36);
    do_op(4'd0, 4'd11, 8'h00);
    do_op(4'd7, 4'd0, 8'h00);

    // Backpressure with in_valid and abort present while DONE.
    a = 4'd5; b = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    check("bp_valid", {7'd0, out_valid}, 8'd1);
    check("bp_product", product, 8'h0F);
    in_valid = 1'b1; a = 4'd1; b = 4'd1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", {7'd0, out_valid}, 8'd1);
      check("bp_hold_product", product, 8'h0F);
      check("bp_in_ready", {7'd0, in_ready}, 8'd0);
    end
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_release_idle", {7'd0, in_ready}, 8'd1);
    check("bp_release_valid", {7'd0, out_valid}, 8'd0);

    // Abort on the 2nd RUN edge.
    a = 4'd12; b = 4'd13; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {7'd0, in_ready}, 8'd1);
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_product", product, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_valid", {7'd0, out_valid}, 8'd0);
    end
    check("abort_product_kept", product, 8'h0F);

    // in_valid held with new operands during RUN is ignored.
    a = 4'd2; b = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    a = 4'd15; b = 4'd15;
    step(); step(); step(); step();
    check("hold_iv_valid", {7'd0, out_valid}, 8'd1);
    check("hold_iv_product", product, 8'h06);
    step();
    check("hold_iv_idle", {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0;
    check("second_accept_busy", {7'd0, busy}, 8'd1);
    step(); step(); step(); step();
    check("second_valid", {7'd0, out_valid}, 8'd1);
    check("second_product", product, 8'hE1);
    step();

    // Reset in the 3rd RUN cycle.
    a = 4'd8; b = 4'd8; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("midrst_product", product, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    check("midrst_in_ready", {7'd0, in_ready}, 8'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("postrst_no_valid", {7'd0, out_valid}, 8'd0);
    end
    do_op(4'd3, 4'd4, 8'h0C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul4_seq_ctrl.md
MUL4_SEQ_CTRL -- requirements
Module: mul4_seq_ctrl

Interface
REQ-001 Parameter: none; operand width is fixed at 4 and taken from the shared package.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  4  multiplicand, unsigned.
REQ-007 b  input  4  multiplier, unsigned.
REQ-008 abort  input  1  synchronous cancel of an operation in progress.
REQ-009 busy  output  1  high in RUN.
REQ-010 out_valid  output  1  product valid; high only in DONE.
REQ-011 out_ready  input  1  consumer accepts the product.
REQ-012 product  output  8  unsigned a*b, registered.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1. A transfer occurs when in_valid & in_ready at a rising edge. On transfer: mcand<=a, lo<=b, hi<=0, iter<=0, state<=RUN.
REQ-015 RUN, per edge: addend = lo[0] ? mcand : 0; {c,s} = hi + addend via the 4-bit adder with cin=0; {hi,lo} <= {c,s,lo[3:1]}; iter<=iter+1.
REQ-016 RUN SHALL last exactly 4 edges. On the 4th edge (iter==3) state<=DONE; product = {hi,lo} after that update.
REQ-017 Latency: out_valid SHALL rise 4 cycles after the accepting edge; no bubbles are allowed.
REQ-018 DONE: out_valid=1 and product is held stable until out_valid & out_ready at an edge; then state<=IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there, with no capture and no error.
REQ-020 Back-to-back: after a DONE->IDLE edge, the next transfer occurs no earlier than the following edge (minimum 6-cycle initiation interval).
REQ-021 abort in RUN: state<=IDLE, out_valid stays 0, and product keeps its previous value.
REQ-022 abort in IDLE or DONE SHALL have no effect; abort has priority over iteration in RUN.
REQ-023 Adder carry-out SHALL never be lost: the width rule is 4+4 -> 5 bits, shifted into hi[3].
REQ-024 Maximum result: 15*15 = 225 fits in 8 bits; no overflow condition exists.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, product=0x00, hi/lo/mcand/iter=0, out_valid=0, busy=0, and in_ready=1 after state settles.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL discard the operation, and no out_valid pulse SHALL follow.
REQ-027 The first transfer is permitted on the first rising edge after rst_n deasserts.

Structure
REQ-028 The shared package SHALL hold OPW=4, ITER=4, and the state enumeration IDLE/RUN/DONE.
REQ-029 The adder SHALL be one sub-module, add4_core: inputs x[3:0], y[3:0], cin; outputs s[3:0], cout; combinational ripple-carry.
REQ-030 The controller SHALL contain no arithmetic other than the iter increment; all additions go through add4_core.

Verification
REQ-031 a=15, b=15, out_ready=1 -> out_valid 4 cycles after acceptance, product=0xE1, for a 1-cycle pulse.
REQ-032 a=9, b=6 -> product=0x36; a=0, b=11 -> 0x00; a=7, b=0 -> 0x00.
REQ-033 Backpressure: a=5, b=3, out_ready=0 for 3 cycles -> out_valid and product=0x0F held; in_ready=0 throughout; IDLE on the out_ready edge.
REQ-034 abort on the 2nd RUN edge with a=12, b=13 -> IDLE next cycle, no out_valid, product unchanged from the prior result.
REQ-035 in_valid held high with new a/b during RUN -> ignored; result matches the first operands; the second pair is accepted only in IDLE.
REQ-036 rst_n low at the 3rd RUN cycle -> outputs go to reset values immediately; no out_valid after release; the next op computes 3*4=0x0C correctly.
